ula_port_fe_audio: RTL and testbench



---
 rtl/ula_pkg.sv | 15 +
 rtl/ula_port_fe_audio_if.sv | 15 +
 rtl/ula_sync_filter.sv | 34 +++
 rtl/ula_port_fe_audio.sv | 108 ++++++++++
 tb/tb_ula_port_fe_audio.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared ULA port constants, default audio weights and common types.
// Pure declarations: no latency, no backpressure.
package ula_pkg;
    localparam int PORT_FE_BORDER_LSB = 0;
    localparam int MIC_BIT            = 3;
    localparam int EAR_BIT            = 4;
    localparam int TAPE_READ_BIT      = 6;

    localparam int DEF_SAMPLE_W    = 16;
    localparam int DEF_EAR_WEIGHT  = 24576;
    localparam int DEF_MIC_WEIGHT  = 4096;
    localparam int DEF_TAPE_WEIGHT = 8192;

    typedef logic [2:0] border_t;
endpackage

// File: rtl/ula_port_fe_audio_if.sv
// CPU-side port bundle: I/O write bus and PCM sample request/response.
// Sample returns one cycle after its strobe; no backpressure (consumer must take every pulse).
interface ula_port_fe_audio_if #(
    parameter int SAMPLE_W = 16
) ();
    logic                io_we;
    logic                addr0;
    logic [7:0]          din;
    logic                sample_stb;
    logic [SAMPLE_W-1:0] pcm;
    logic                pcm_valid;

    modport master (output io_we, addr0, din, sample_stb, input pcm, pcm_valid);
    modport slave  (input io_we, addr0, din, sample_stb, output pcm, pcm_valid);
endinterface

// File: rtl/ula_sync_filter.sv
// Two-flop synchroniser plus stability filter; q follows d_async after 2 + FILTER_LEN stable cycles.
// No handshake: shorter pulses are swallowed.
module ula_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic q
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // q flips on the cycle the count would reach FILTER_LEN
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            q    <= 1'b0;
        end else begin
            sync <= {sync[0], d_async};
            if (sync[1] == q) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                q   <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ula_port_fe_audio.sv
// Port 0xFE latch, tape filter, weighted PCM + sigma-delta audio and activity LED.
// Writes and samples land 1 cycle later; no backpressure on either path.
module ula_port_fe_audio
    import ula_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int EAR_WEIGHT  = DEF_EAR_WEIGHT,
    parameter int MIC_WEIGHT  = DEF_MIC_WEIGHT,
    parameter int TAPE_WEIGHT = DEF_TAPE_WEIGHT,
    parameter int FILTER_LEN  = 4,
    parameter int LED_DIV_W   = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    ula_port_fe_audio_if.slave        bus,
    input  logic                      tape_in,
    input  logic                      tape_monitor,
    output border_t                   border,
    output logic                      mic,
    output logic                      ear,
    output logic                      tape_bit,
    output logic                      dsm_out,
    output logic                      activity_led
);
    localparam int LW = SAMPLE_W + 2;

    if (SAMPLE_W < 8 || SAMPLE_W > 24) begin : g_bad_sample_w
        $error("SAMPLE_W must be within 8..24");
    end
    if (EAR_WEIGHT < 0 || EAR_WEIGHT >= (1 << SAMPLE_W)) begin : g_bad_ear_w
        $error("EAR_WEIGHT must fit in SAMPLE_W bits");
    end
    if (MIC_WEIGHT < 0 || MIC_WEIGHT >= (1 << SAMPLE_W)) begin : g_bad_mic_w
        $error("MIC_WEIGHT must fit in SAMPLE_W bits");
    end
    if (TAPE_WEIGHT < 0 || TAPE_WEIGHT >= (1 << SAMPLE_W)) begin : g_bad_tape_w
        $error("TAPE_WEIGHT must fit in SAMPLE_W bits");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("FILTER_LEN must be at least 1");
    end
    if (LED_DIV_W < 1) begin : g_bad_led_div
        $error("LED_DIV_W must be at least 1");
    end

    logic [LW-1:0]        sum;
    logic [SAMPLE_W-1:0]  level;
    logic [SAMPLE_W:0]    acc;
    logic                 act_r;
    logic                 act_prev;
    logic [LED_DIV_W-1:0] led_cnt;
    logic                 unused_din;

    assign unused_din = ^bus.din[7:5];

    ula_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_tape_filter (
        .clk     (clk),
        .reset   (reset),
        .d_async (tape_in),
        .q       (tape_bit)
    );

    // Two guard bits hold the worst-case three-way sum before clamping
    always_comb begin
        sum = '0;
        if (ear)                     sum = sum + LW'(EAR_WEIGHT);
        if (mic)                     sum = sum + LW'(MIC_WEIGHT);
        if (tape_monitor && tape_bit) sum = sum + LW'(TAPE_WEIGHT);
        level = (|sum[LW-1:SAMPLE_W]) ? '1 : sum[SAMPLE_W-1:0];
    end

    // The accumulator MSB is the carry of the last add, i.e. the bitstream
    assign dsm_out = acc[SAMPLE_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            border        <= '0;
            mic           <= 1'b0;
            ear           <= 1'b0;
            bus.pcm       <= '0;
            bus.pcm_valid <= 1'b0;
            acc           <= '0;
            act_r         <= 1'b0;
            act_prev      <= 1'b0;
            led_cnt       <= '0;
            activity_led  <= 1'b0;
        end else begin
            if (bus.io_we && !bus.addr0) begin
                border <= bus.din[PORT_FE_BORDER_LSB +: $bits(border_t)];
                mic    <= bus.din[MIC_BIT];
                ear    <= bus.din[EAR_BIT];
            end
            if (bus.sample_stb) begin
                bus.pcm <= level;
            end
            bus.pcm_valid <= bus.sample_stb;
            acc           <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, level};
            act_r         <= ear ^ mic ^ tape_bit;
            act_prev      <= act_r;
            if (act_r && !act_prev) begin
                if (led_cnt == '0) begin
                    activity_led <= ~activity_led;
                end
                led_cnt <= led_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ula_port_fe_audio.sv
// Bench for ula_port_fe_audio: default-weight DUT plus a saturating-weight twin sharing stimulus.
module tb_ula_port_fe_audio;
    import ula_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    reset, tape_in, tape_monitor;
    border_t border, s_border;
    logic    mic, ear, tape_bit, dsm_out, activity_led;
    logic    s_mic, s_ear, s_tape_bit, s_dsm_out, s_activity_led;

    ula_port_fe_audio_if #(.SAMPLE_W(16)) bus  ();
    ula_port_fe_audio_if #(.SAMPLE_W(16)) sbus ();

    ula_port_fe_audio u_dut (
        .clk(clk), .reset(reset), .bus(bus), .tape_in(tape_in), .tape_monitor(tape_monitor),
        .border(border), .mic(mic), .ear(ear), .tape_bit(tape_bit), .dsm_out(dsm_out),
        .activity_led(activity_led)
    );

    ula_port_fe_audio #(.EAR_WEIGHT(40000), .MIC_WEIGHT(40000), .TAPE_WEIGHT(40000)) u_sat (
        .clk(clk), .reset(reset), .bus(sbus), .tape_in(tape_in), .tape_monitor(tape_monitor),
        .border(s_border), .mic(s_mic), .ear(s_ear), .tape_bit(s_tape_bit), .dsm_out(s_dsm_out),
        .activity_led(s_activity_led)
    );

    int total = 0;
    int bad   = 0;
    int q_main[$];
    int q_sat[$];

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Scoreboards: each pcm_valid pulse consumes one expected sample
    always @(negedge clk) begin
        if (bus.pcm_valid === 1'b1) begin
            if (q_main.size() == 0) begin
                total++; bad++;
                $display("FAIL main_spurious_valid: pcm=%0d with no strobe outstanding", bus.pcm);
            end else begin
                chk("main_pcm", longint'(bus.pcm), longint'(q_main.pop_front()));
            end
        end
        if (sbus.pcm_valid === 1'b1) begin
            if (q_sat.size() == 0) begin
                total++; bad++;
                $display("FAIL sat_spurious_valid: pcm=%0d with no strobe outstanding", sbus.pcm);
            end else begin
                chk("sat_pcm", longint'(sbus.pcm), longint'(q_sat.pop_front()));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic a0, input logic [7:0] d, input logic stb);
        bus.io_we  = we;  bus.addr0  = a0; bus.din  = d; bus.sample_stb  = stb;
        sbus.io_we = we;  sbus.addr0 = a0; sbus.din = d; sbus.sample_stb = stb;
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        drive(1'b1, a0, d, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic stb(input int exp_main, input int exp_sat);
        q_main.push_back(exp_main);
        q_sat.push_back(exp_sat);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int lat, hi, ones;
        reset = 1'b1; tape_in = 1'b0; tape_monitor = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_border", border, 0);
        chk("rst_mic", mic, 0);
        chk("rst_ear", ear, 0);
        chk("rst_tape_bit", tape_bit, 0);
        chk("rst_pcm", bus.pcm, 0);
        chk("rst_pcm_valid", bus.pcm_valid, 0);
        chk("rst_dsm", dsm_out, 0);
        chk("rst_led", activity_led, 0);

        wr(1'b0, 8'h15);
        chk("wr_border", border, 5);
        chk("wr_mic", mic, 0);
        chk("wr_ear", ear, 1);
        wr(1'b1, 8'hFF);
        chk("odd_border", border, 5);
        chk("odd_mic", mic, 0);
        chk("odd_ear", ear, 1);

        // Tape path: latency, short-pulse rejection, minimum accepted pulse
        tape_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (tape_bit) lat = k;
        end
        chk("tape_latency", lat, 6);
        tape_in = 1'b0;
        repeat (10) tick();
        chk("tape_back_low", tape_bit, 0);
        tape_in = 1'b1;
        repeat (3) tick();
        tape_in = 1'b0;
        hi = 0;
        repeat (12) begin tick(); if (tape_bit) hi++; end
        chk("tape_short_pulse", hi, 0);
        tape_in = 1'b1;
        repeat (4) tick();
        tape_in = 1'b0;
        hi = 0;
        repeat (12) begin tick(); if (tape_bit) hi++; end
        chk("tape_min_pulse", hi, 4);

        // Mixing and saturation
        tape_in = 1'b1;
        repeat (8) tick();
        chk("tape_high", tape_bit, 1);
        tape_monitor = 1'b1;
        wr(1'b0, 8'h18);
        stb(36864, 65535);
        repeat (3) tick();
        chk("pcm_hold", bus.pcm, 36864);
        chk("sat_hold", sbus.pcm, 65535);
        q_main.push_back(36864); q_sat.push_back(65535);
        q_main.push_back(36864); q_sat.push_back(65535);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("b2b_valid_first", bus.pcm_valid, 1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("b2b_valid_second", bus.pcm_valid, 1);
        tick();
        chk("b2b_valid_drop", bus.pcm_valid, 0);
        tape_monitor = 1'b0;
        stb(28672, 65535);
        wr(1'b0, 8'h08);
        stb(4096, 40000);
        wr(1'b0, 8'h00);
        tape_monitor = 1'b1;
        stb(8192, 40000);
        tape_monitor = 1'b0;

        // Write and strobe in the same cycle: sample sees the old ear
        q_main.push_back(0); q_sat.push_back(0);
        drive(1'b1, 1'b0, 8'h10, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("same_cycle_ear", ear, 1);
        stb(24576, 40000);
        repeat (4) tick();

        // Reset mid-run with a write and strobe in the reset cycle
        tape_in = 1'b0;
        reset = 1'b1;
        drive(1'b1, 1'b0, 8'h07, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_pcm", bus.pcm, 0);
        chk("midrst_valid", bus.pcm_valid, 0);
        chk("midrst_dsm", dsm_out, 0);
        chk("midrst_border", border, 0);
        chk("midrst_ear", ear, 0);
        chk("midrst_sat_pcm", sbus.pcm, 0);
        reset = 1'b0;
        tick();

        // Sigma-delta density
        ones = 0;
        repeat (100) begin tick(); ones += int'(dsm_out); end
        chk("dsm_level0", ones, 0);
        wr(1'b0, 8'h10);
        ones = 0;
        repeat (65536) begin tick(); ones += int'(dsm_out); end
        total++;
        if (ones < 24575 || ones > 24577) begin
            bad++;
            $display("FAIL dsm_density: ones=%0d required 24576 +/-1", ones);
        end

        // Activity LED divider
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 129; i++) begin
            wr(1'b0, 8'h10);
            wr(1'b0, 8'h00);
            tick();
            tick();
            chk($sformatf("led_edge%0d", i), activity_led, (i < 129) ? 1 : 0);
        end

        repeat (2) tick();
        chk("main_queue_drained", q_main.size(), 0);
        chk("sat_queue_drained", q_sat.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
